// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer
// Purpose  : Loads a WIDTH-bit parallel word on a valid/ready handshake and
//            shifts it out one bit per clock on x, MSB or LSB first. A stall
//            input freezes shifting. Back-to-back words are joined with no
//            idle bubble, so the serial stream can feed a sequence detector
//            continuously.
// Ports    : clk       - single clock, all state changes on posedge
//            reset     - synchronous, active-high
//            din       - parallel word (WIDTH bits)
//            din_valid - din holds a word ready for transfer
//            din_ready - word accepted on this edge (combinational)
//            stall     - freezes shift register, counter and x
//            x         - serial data bit
//            x_valid   - x carries a real data bit this cycle
//            busy      - a word is being shifted out
//            done      - one-cycle pulse after the last bit is consumed
//            word_cnt  - completed word count, wraps 255 -> 0
// Revision : 1.0 - initial release
// ============================================================================
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             stall,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [7:0]       word_cnt
);

    localparam int               C_CNT_W = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [7:0]         word_cnt_q, word_cnt_d;

    logic               w_head;
    logic               w_consume;
    logic               w_last;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_shifted;

    always_comb begin
        w_head    = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        w_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, sreg_q[WIDTH-1:1]};
        w_consume = (state_q == ST_SHIFT) && !stall;
        w_last    = w_consume && (cnt_q == C_LAST);
        // Ready in IDLE, or exactly when the final bit leaves so the next
        // word can be loaded on the same edge without a bubble.
        din_ready = !reset && ((state_q == ST_IDLE) || w_last);
        w_xfer    = din_valid && din_ready;
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        done_d     = w_last;
        word_cnt_d = w_last ? word_cnt_q + 8'd1 : word_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_xfer) begin
                    sreg_d  = din;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_consume) begin
                    if (w_last) begin
                        if (w_xfer) begin
                            sreg_d = din;
                            cnt_d  = '0;
                        end else begin
                            sreg_d  = '0;
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sreg_d = w_shifted;
                        cnt_d  = cnt_q + C_CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // x holds the head bit through a stall; only x_valid drops.
    assign x        = (state_q == ST_SHIFT) && w_head;
    assign x_valid  = w_consume;
    assign busy     = (state_q == ST_SHIFT);
    assign done     = done_q;
    assign word_cnt = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serializer
// Purpose  : Self-checking bench for bit_serializer. Two instances (MSB-first
//            and LSB-first) share one stimulus stream; a word-level reference
//            model (current word + index of the next bit) predicts every
//            output each cycle, and directed scenarios add sequence checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic         stall;

    logic         m_ready, m_x, m_xv, m_busy, m_done;
    logic [7:0]   m_wcnt;
    logic         l_ready, l_x, l_xv, l_busy, l_done;
    logic [7:0]   l_wcnt;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(m_ready), .stall(stall), .x(m_x), .x_valid(m_xv),
        .busy(m_busy), .done(m_done), .word_cnt(m_wcnt)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(l_ready), .stall(stall), .x(l_x), .x_valid(l_xv),
        .busy(l_busy), .done(l_done), .word_cnt(l_wcnt)
    );

    wire [12:0] m_vec = {m_ready, m_busy, m_xv, m_x, m_done, m_wcnt};
    wire [12:0] l_vec = {l_ready, l_busy, l_xv, l_x, l_done, l_wcnt};

    // Reference model: the word in flight and how many of its bits are gone.
    logic [W-1:0] cur   = '0;
    int           k     = 0;
    bit           mbusy = 1'b0;
    bit           mdone = 1'b0;
    logic [7:0]   mwcnt = '0;

    function automatic logic exp_ready();
        return !reset && (!mbusy || (k == W - 1 && !stall));
    endfunction

    function automatic logic [12:0] exp_vec(input bit msb);
        logic xb;
        xb = mbusy ? (msb ? cur[W-1-k] : cur[k]) : 1'b0;
        return {exp_ready(), logic'(mbusy), logic'(mbusy && !stall), xb,
                logic'(mdone), mwcnt};
    endfunction

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic advance();
        logic rdy, cons, last;
        @(posedge clk);
        rdy  = exp_ready();
        cons = mbusy && !stall;
        last = cons && (k == W - 1);
        if (reset) begin
            mbusy = 1'b0; k = 0; mdone = 1'b0; mwcnt = '0; cur = '0;
        end else begin
            mdone = last;
            if (last) mwcnt = mwcnt + 8'd1;
            if (din_valid && rdy) begin
                cur = din; k = 0; mbusy = 1'b1;
            end else if (last) begin
                mbusy = 1'b0;
            end else if (cons) begin
                k = k + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; din_valid = 1'b0; stall = 1'b0; din = '0;
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            reset = 1'b1; din_valid = 1'b1; din = W'($urandom); stall = 1'(i);
            advance();
            #1;
            vectors++;
            if ({m_vec, l_vec} !== {exp_vec(1'b1), exp_vec(1'b0)}) begin
                fails++;
                $display("FAIL reset cyc %0d: dut %h model %h", i, {m_vec, l_vec}, {exp_vec(1'b1), exp_vec(1'b0)});
            end
            vectors++;
            if ({m_ready, l_ready, m_busy, m_wcnt} !== 11'd0) begin
                fails++;
                $display("FAIL reset_idle cyc %0d: got %b want 0", i, {m_ready, l_ready, m_busy, m_wcnt});
            end
        end
        reset = 1'b0; din_valid = 1'b0; stall = 1'b0;
    endtask

    task automatic test_single_word(input logic [7:0] w, input logic [7:0] exp_m,
                                    input logic [7:0] exp_l);
        logic [7:0] sm, sl;
        int nb, nd, first;
        do_reset();
        sm = '0; sl = '0; nb = 0; nd = 0; first = -1;
        for (int i = 0; i < 14; i++) begin
            din_valid = (i == 0); din = w;
            #1;
            vectors++;
            if ({m_vec, l_vec} !== {exp_vec(1'b1), exp_vec(1'b0)}) begin
                fails++;
                $display("FAIL single_word cyc %0d: dut %h model %h", i, {m_vec, l_vec}, {exp_vec(1'b1), exp_vec(1'b0)});
            end
            if (m_xv) begin
                sm = {sm[6:0], m_x}; nb++;
                if (first < 0) first = i;
            end
            if (l_xv) sl = {sl[6:0], l_x};
            if (m_done) nd++;
            advance();
        end
        vectors++;
        if ({sm, sl} !== {exp_m, exp_l} || nb != 8 || first != 1) begin
            fails++;
            $display("FAIL single_word_seq: got msb %h lsb %h n %0d first %0d want %h %h 8 1", sm, sl, nb, first, exp_m, exp_l);
        end
        vectors++;
        if (nd != 1 || m_wcnt !== 8'd1 || l_wcnt !== 8'd1) begin
            fails++;
            $display("FAIL single_word_done: got done %0d wcnt %0d want 1 1", nd, m_wcnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  words [2];
        logic [15:0] seq;
        int wi, nb, nd, first, last;
        logic acc;
        words[0] = 8'hFF; words[1] = 8'h00;
        do_reset();
        seq = '0; wi = 0; nb = 0; nd = 0; first = -1; last = -1;
        for (int i = 0; i < 22; i++) begin
            din_valid = (wi < 2); din = (wi < 2) ? words[wi] : 8'h5A;
            #1;
            vectors++;
            if ({m_vec, l_vec} !== {exp_vec(1'b1), exp_vec(1'b0)}) begin
                fails++;
                $display("FAIL back_to_back cyc %0d: dut %h model %h", i, {m_vec, l_vec}, {exp_vec(1'b1), exp_vec(1'b0)});
            end
            if (m_xv) begin
                seq = {seq[14:0], m_x}; nb++; last = i;
                if (first < 0) first = i;
            end
            if (m_done) nd++;
            acc = din_valid && exp_ready();
            advance();
            if (acc) wi++;
        end
        vectors++;
        if (seq !== 16'hFF00 || nb != 16 || last - first != 15) begin
            fails++;
            $display("FAIL back_to_back_seq: got %h n %0d span %0d want ff00 16 15", seq, nb, last - first);
        end
        vectors++;
        if (nd != 2 || m_wcnt !== 8'd2) begin
            fails++;
            $display("FAIL back_to_back_done: got done %0d wcnt %0d want 2 2", nd, m_wcnt);
        end
    endtask

    task automatic test_stall();
        logic [7:0] seq;
        int nb, nd, leak, third;
        do_reset();
        seq = '0; nb = 0; nd = 0; leak = 0; third = -1;
        for (int i = 0; i < 16; i++) begin
            din_valid = (i == 0); din = 8'hA5; stall = (i >= 3 && i <= 5);
            #1;
            vectors++;
            if ({m_vec, l_vec} !== {exp_vec(1'b1), exp_vec(1'b0)}) begin
                fails++;
                $display("FAIL stall cyc %0d: dut %h model %h", i, {m_vec, l_vec}, {exp_vec(1'b1), exp_vec(1'b0)});
            end
            if (stall && m_xv) leak++;
            if (m_xv) begin
                seq = {seq[6:0], m_x}; nb++;
                if (nb == 3) third = i;
            end
            if (m_done) nd++;
            advance();
        end
        stall = 1'b0;
        vectors++;
        if (seq !== 8'hA5 || nb != 8 || leak != 0 || third != 6 || nd != 1) begin
            fails++;
            $display("FAIL stall_seq: got %h n %0d leak %0d third %0d done %0d want a5 8 0 6 1", seq, nb, leak, third, nd);
        end
    endtask

    task automatic test_reset_mid();
        int nb, nd;
        do_reset();
        nb = 0; nd = 0;
        for (int i = 0; i < 18; i++) begin
            din_valid = (i == 0); din = 8'hF0; reset = (i == 5);
            #1;
            vectors++;
            if ({m_vec, l_vec} !== {exp_vec(1'b1), exp_vec(1'b0)}) begin
                fails++;
                $display("FAIL reset_mid cyc %0d: dut %h model %h", i, {m_vec, l_vec}, {exp_vec(1'b1), exp_vec(1'b0)});
            end
            if (i < 5 && m_xv) nb++;
            if (m_done) nd++;
            if (i == 6) begin
                vectors++;
                if ({m_busy, m_xv, m_x} !== 3'b000) begin
                    fails++;
                    $display("FAIL reset_mid_abort: got busy/xv/x %b want 000", {m_busy, m_xv, m_x});
                end
            end
            advance();
        end
        reset = 1'b0;
        vectors++;
        if (nb != 4 || nd != 0 || m_wcnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_cnt: got bits %0d done %0d wcnt %0d want 4 0 0", nb, nd, m_wcnt);
        end
    endtask

    task automatic test_ready_hold();
        logic [7:0]  w1, w2;
        logic [15:0] seq;
        int accn;
        logic acc;
        w1 = 8'($urandom); w2 = 8'($urandom);
        do_reset();
        seq = '0; accn = 0;
        for (int i = 0; i < 20; i++) begin
            din_valid = (accn < 2); din = (accn == 0) ? w1 : w2;
            #1;
            vectors++;
            if ({m_vec, l_vec} !== {exp_vec(1'b1), exp_vec(1'b0)}) begin
                fails++;
                $display("FAIL ready_hold cyc %0d: dut %h model %h", i, {m_vec, l_vec}, {exp_vec(1'b1), exp_vec(1'b0)});
            end
            if (i >= 1 && i <= 8) begin
                vectors++;
                if (m_ready !== (i == 8)) begin
                    fails++;
                    $display("FAIL ready_hold_ready cyc %0d: got %b want %b", i, m_ready, (i == 8));
                end
            end
            if (m_xv) seq = {seq[14:0], m_x};
            acc = din_valid && exp_ready();
            advance();
            if (acc) accn++;
        end
        vectors++;
        if (seq !== {w1, w2} || accn != 2) begin
            fails++;
            $display("FAIL ready_hold_seq: got %h acc %0d want %h 2", seq, accn, {w1, w2});
        end
    endtask

    task automatic test_wrap();
        int accn, nd;
        logic acc;
        do_reset();
        accn = 0; nd = 0; din = 8'($urandom);
        for (int i = 0; i < 2600; i++) begin
            din_valid = (accn < 256);
            stall = ($urandom_range(0, 15) == 0);
            #1;
            vectors++;
            if ({m_vec, l_vec} !== {exp_vec(1'b1), exp_vec(1'b0)}) begin
                fails++;
                $display("FAIL wrap cyc %0d: dut %h model %h", i, {m_vec, l_vec}, {exp_vec(1'b1), exp_vec(1'b0)});
            end
            if (m_done) nd++;
            acc = din_valid && exp_ready();
            advance();
            if (acc) begin
                accn++;
                din = 8'($urandom);
            end
        end
        stall = 1'b0;
        vectors++;
        if (accn != 256 || nd != 256 || m_wcnt !== 8'd0 || l_wcnt !== 8'd0) begin
            fails++;
            $display("FAIL wrap_cnt: got acc %0d done %0d wcnt %0d want 256 256 0", accn, nd, m_wcnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            din_valid = 1'($urandom);
            stall     = ($urandom_range(0, 3) == 0);
            din       = 8'($urandom);
            #1;
            vectors++;
            if ({m_vec, l_vec} !== {exp_vec(1'b1), exp_vec(1'b0)}) begin
                fails++;
                $display("FAIL random cyc %0d: dut %h model %h", i, {m_vec, l_vec}, {exp_vec(1'b1), exp_vec(1'b0)});
            end
            advance();
        end
        reset = 1'b0; din_valid = 1'b0; stall = 1'b0;
    endtask

    initial begin
        reset = 1'b1; din = '0; din_valid = 1'b0; stall = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_word(8'b11100011, 8'hE3, 8'hC7);
        test_single_word(8'b00000111, 8'h07, 8'hE0);
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_ready_hold();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: number of bits in each parallel word (WIDTH >= 2).
REQ-002 Parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
REQ-003 clk  input  1  single clock; all state changes on the posedge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word that is ready for transfer.
REQ-007 din_ready  output  1  the block accepts din on this clock edge.
REQ-008 stall  input  1  freezes shifting while high.
REQ-009 x  output  1  serial bit stream feeding the sequence-detector FSM input.
REQ-010 x_valid  output  1  x carries a real data bit this cycle.
REQ-011 busy  output  1  a word is being shifted out.
REQ-012 done  output  1  one-cycle pulse after the last bit of a word is consumed.
REQ-013 word_cnt  output  8  count of completed words, wraps from 255 to 0.

Function
REQ-014 The state machine SHALL have two states: IDLE and SHIFT, plus an internal bit counter cnt of width ceil(log2(WIDTH)).
REQ-015 A transfer SHALL occur on a posedge where din_valid and din_ready are both 1; din is loaded into the shift register, cnt is set to 0, and state becomes SHIFT.
REQ-016 din_ready SHALL be driven combinationally: 1 in IDLE, and 1 in SHIFT only when cnt==WIDTH-1 and stall==0; otherwise 0.
REQ-017 The first bit SHALL appear on x in the cycle after the transfer (latency 1 clock).
REQ-018 In SHIFT with stall==0, x SHALL be the current head bit (MSB or LSB per MSB_FIRST) and x_valid SHALL be 1; at the posedge the register shifts by one and cnt increments.
REQ-019 In SHIFT with stall==1, the shift register, cnt and x SHALL hold, and x_valid SHALL be 0.
REQ-020 When the bit at cnt==WIDTH-1 is consumed, done SHALL be 1 for exactly the next cycle and word_cnt SHALL increment by 1 (wraps at 255).
REQ-021 If a transfer coincides with consumption of the last bit, the new word SHALL load with no idle bubble: x_valid stays 1 continuously across the word boundary.
REQ-022 If the last bit is consumed and no transfer occurs, state SHALL return to IDLE.
REQ-023 In IDLE, x SHALL be 0, x_valid 0 and busy 0; busy SHALL equal (state==SHIFT).
REQ-024 din_valid asserted while din_ready==0 SHALL be ignored; din is not sampled, and the source must hold it.
REQ-025 A stall asserted in IDLE SHALL have no effect on accepting a word.

Reset
REQ-026 While reset is 1 at a posedge, state SHALL go to IDLE, and the shift register, cnt, done and word_cnt SHALL be cleared to 0; reset takes priority over any transfer.
REQ-027 A reset mid-word SHALL abort the word: no done pulse and no word_cnt increment; x and x_valid read 0 from the next cycle.
REQ-028 din_ready SHALL be 0 while reset is 1.

Verification
REQ-029 Reset, then transfer din=8'b11100011 with MSB_FIRST=1 -> x=1,1,1,0,0,0,1,1 on 8 consecutive x_valid cycles starting 1 cycle after the transfer; done pulses once; word_cnt=1.
REQ-030 Back-to-back words 8'hFF then 8'h00, with din_valid held high -> 16 contiguous x_valid cycles, x=eight 1s then eight 0s; done pulses twice; word_cnt=2.
REQ-031 Word 8'hA5 with stall high for 3 cycles after the 2nd bit -> x_valid=0 for those 3 cycles, then resumes at the 3rd bit with sequence 1,0,1,0,0,1,0,1 intact.
REQ-032 Reset asserted after the 4th bit of 8'hF0 -> next cycle busy=0, x_valid=0, done never pulses, word_cnt=0.
REQ-033 MSB_FIRST=0, din=8'b00000111 -> x=1,1,1,0,0,0,0,0.
REQ-034 din_valid high with a new word during mid-word bits -> din_ready=0 and the word is not accepted until cnt==WIDTH-1; 256 completed words -> word_cnt wraps to 0.
